// File: rtl/mipi_csi_rx_frame_controller_pkg.sv
// Shared constants, state encoding and the beat-count helper for the CSI-2 frame controller.
package mipi_csi_rx_frame_controller_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [7:0] DT_FS     = 8'h00;
    localparam logic [7:0] DT_FE     = 8'h01;
    localparam logic [7:0] DT_RAW10  = 8'h2B;
    localparam logic [7:0] DT_RAW12  = 8'h2C;
    localparam logic [7:0] DT_RAW14  = 8'h2D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

    // Index of the last beat of a line: ceil(len/beat_bytes)-1, floored at 0.
    function automatic logic [15:0] last_beat(input logic [15:0] len, input int beat_bytes);
        logic [16:0] sum;
        logic [16:0] beats;
        sum   = {1'b0, len} + 17'(beat_bytes - 1);
        beats = sum / 17'(beat_bytes);
        return (beats == 17'd0) ? 16'd0 : 16'(beats - 17'd1);
    endfunction
endpackage

// File: rtl/mipi_csi_rx_frame_controller.sv
// CSI-2 receive frame/line tracker: decodes FS/FE short packets, counts lines,
// checks line length and line count, and aborts stalled frames via an idle timer.
module mipi_csi_rx_frame_controller
    import mipi_csi_rx_frame_controller_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
    parameter int          LANES          = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_valid_i,
    input  logic [63:0] data_i,
    input  logic        decoder_valid_i,
    input  logic [15:0] packet_length_i,
    input  logic [15:0] expected_lines_i,
    output logic        frame_valid_o,
    output logic        line_valid_o,
    output logic [15:0] line_count_o,
    output logic [15:0] frame_number_o,
    output logic [3:0]  error_o
);
    localparam int BEAT_BYTES = LANES * 2;

    state_t      state;
    logic [15:0] beat_cnt;
    logic [15:0] idle_cnt;

    logic        is_short, is_fs, is_fe, line_end, timeout;
    logic [15:0] line_count_inc;
    logic        unused_data_bits;

    assign is_short = data_valid_i && (data_i[7:0] == SYNC_BYTE);
    assign is_fs    = is_short && (data_i[15:8] == DT_FS);
    assign is_fe    = is_short && (data_i[15:8] == DT_FE);
    assign line_end = !decoder_valid_i || !data_valid_i;
    assign timeout  = idle_cnt >= (TIMEOUT_CYCLES - 16'd1);
    assign line_count_inc = (line_count_o == 16'hFFFF) ? line_count_o : line_count_o + 16'd1;
    assign unused_data_bits = ^{data_i[63:48], data_i[39:32], data_i[23:16]};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= ST_IDLE;
            beat_cnt       <= '0;
            idle_cnt       <= '0;
            frame_valid_o  <= 1'b0;
            line_valid_o   <= 1'b0;
            line_count_o   <= '0;
            frame_number_o <= '0;
            error_o        <= '0;
        end else if (is_fs) begin
            // A Frame Start always (re)opens a frame; only a restart flags error[1].
            state          <= ST_FRAME;
            beat_cnt       <= '0;
            idle_cnt       <= '0;
            frame_valid_o  <= 1'b1;
            line_valid_o   <= 1'b0;
            line_count_o   <= '0;
            frame_number_o <= {data_i[47:40], data_i[31:24]};
            error_o        <= (state == ST_IDLE) ? 4'b0000 : 4'b0010;
        end else begin
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (is_fe) error_o[0] <= 1'b1;
                end
                ST_FRAME: begin
                    if (is_fe) begin
                        state         <= ST_IDLE;
                        frame_valid_o <= 1'b0;
                        idle_cnt      <= '0;
                        if (expected_lines_i != 16'd0 && line_count_o != expected_lines_i)
                            error_o[3] <= 1'b1;
                    end else if (decoder_valid_i) begin
                        state        <= ST_LINE;
                        line_valid_o <= 1'b1;
                        idle_cnt     <= '0;
                        beat_cnt     <= last_beat(packet_length_i, BEAT_BYTES);
                    end else if (is_short) begin
                        idle_cnt <= '0;
                    end else if (timeout) begin
                        state         <= ST_IDLE;
                        frame_valid_o <= 1'b0;
                        idle_cnt      <= '0;
                        error_o[2]    <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                ST_LINE: begin
                    idle_cnt <= '0;
                    if (is_fe || line_end) begin
                        // FE inside a line closes the line first, so the count check sees it.
                        line_valid_o <= 1'b0;
                        line_count_o <= line_count_inc;
                        if (is_fe) begin
                            state         <= ST_IDLE;
                            frame_valid_o <= 1'b0;
                            error_o[3]    <= error_o[3] || (beat_cnt != 16'd0) ||
                                             (expected_lines_i != 16'd0 && line_count_inc != expected_lines_i);
                        end else begin
                            state      <= ST_FRAME;
                            error_o[3] <= error_o[3] || (beat_cnt != 16'd0);
                        end
                    end else if (beat_cnt != 16'd0) begin
                        beat_cnt <= beat_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mipi_csi_rx_frame_controller.sv
// Directed bench for the CSI-2 frame controller with an expected-output queue.
module tb_mipi_csi_rx_frame_controller;
    typedef struct packed {
        logic        fv;
        logic        lv;
        logic [15:0] lc;
        logic [15:0] fn;
        logic [3:0]  err;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid = 1'b0;
    logic [63:0] data = '0;
    logic        decoder_valid = 1'b0;
    logic [15:0] packet_length = '0;
    logic [15:0] expected_lines = '0;
    logic        frame_valid, line_valid;
    logic [15:0] line_count, frame_number;
    logic [3:0]  error;
    out_t        obs;

    out_t  exp_q[$];
    string tag_q[$];
    int    compared = 0;
    int    mismatched = 0;

    mipi_csi_rx_frame_controller dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .data_valid_i    (data_valid),
        .data_i          (data),
        .decoder_valid_i (decoder_valid),
        .packet_length_i (packet_length),
        .expected_lines_i(expected_lines),
        .frame_valid_o   (frame_valid),
        .line_valid_o    (line_valid),
        .line_count_o    (line_count),
        .frame_number_o  (frame_number),
        .error_o         (error)
    );

    always #5 clk = ~clk;
    assign obs = {frame_valid, line_valid, line_count, frame_number, error};

    function automatic out_t ex(input logic fv, input logic lv, input logic [15:0] lc,
                                input logic [15:0] fn, input logic [3:0] err);
        out_t e;
        e.fv = fv; e.lv = lv; e.lc = lc; e.fn = fn; e.err = err;
        return e;
    endfunction

    task automatic expect_out(input string tag, input out_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_out();
        out_t  e;
        string tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed fv=%0b lv=%0b lc=%0d fn=%0d err=%b, expected fv=%0b lv=%0b lc=%0d fn=%0d err=%b",
                   tag, obs.fv, obs.lv, obs.lc, obs.fn, obs.err, e.fv, e.lv, e.lc, e.fn, e.err);
        end
    endtask

    // Queue the expected result for the inputs now on the bus, clock once, then compare.
    task automatic step(input string tag, input out_t e);
        expect_out(tag, e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic set_quiet();
        data_valid    = 1'b0;
        data          = '0;
        decoder_valid = 1'b0;
    endtask

    task automatic set_sp(input logic [7:0] id, input logic [15:0] fn);
        data_valid    = 1'b1;
        decoder_valid = 1'b0;
        data          = '0;
        data[7:0]     = 8'hB8;
        data[15:8]    = id;
        data[31:24]   = fn[7:0];
        data[47:40]   = fn[15:8];
    endtask

    task automatic set_beat(input logic [15:0] len);
        data_valid    = 1'b1;
        decoder_valid = 1'b1;
        packet_length = len;
        data          = {$urandom(), $urandom()};
        data[7:0]     = 8'h55;
    endtask

    task automatic do_reset();
        set_quiet();
        rst = 1'b1;
        #1;
        expect_out("reset_async", ex(0, 0, 0, 0, 4'b0000));
        compare_out();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        expect_out("reset_state", ex(0, 0, 0, 0, 4'b0000));
        compare_out();
        rst = 1'b0;

        // Full frame: FS #5, three 1280 B lines, FE with matching line count
        expected_lines = 16'd3;
        set_sp(8'h00, 16'h0005);
        step("fs_open", ex(1, 0, 0, 5, 4'b0000));
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 160; b++) begin
                set_beat(16'd1280);
                step($sformatf("line%0d_beat%0d", k, b), ex(1, 1, 16'(k), 5, 4'b0000));
            end
            set_quiet();
            step($sformatf("line%0d_end", k), ex(1, 0, 16'(k + 1), 5, 4'b0000));
            step($sformatf("line%0d_gap", k), ex(1, 0, 16'(k + 1), 5, 4'b0000));
        end
        set_sp(8'h01, 16'h0000);
        step("fe_close", ex(0, 0, 3, 5, 4'b0000));
        set_quiet();
        step("after_fe", ex(0, 0, 3, 5, 4'b0000));

        // FE with no FS
        do_reset();
        set_sp(8'h01, 16'h0000);
        step("fe_no_fs", ex(0, 0, 0, 0, 4'b0001));
        set_quiet();
        step("fe_no_fs_hold", ex(0, 0, 0, 0, 4'b0001));

        // FS inside FRAME, then FS inside LINE
        do_reset();
        expected_lines = 16'd0;
        set_sp(8'h00, 16'd7);
        step("fs7", ex(1, 0, 0, 7, 4'b0000));
        set_beat(16'd16);
        step("l16_b0", ex(1, 1, 0, 7, 4'b0000));
        set_beat(16'd16);
        step("l16_b1", ex(1, 1, 0, 7, 4'b0000));
        set_quiet();
        step("l16_end", ex(1, 0, 1, 7, 4'b0000));
        set_sp(8'h00, 16'd8);
        step("fs_in_frame", ex(1, 0, 0, 8, 4'b0010));
        set_beat(16'd64);
        step("l64_b0", ex(1, 1, 0, 8, 4'b0010));
        set_sp(8'h00, 16'h1234);
        step("fs_in_line", ex(1, 0, 0, 16'h1234, 4'b0010));

        // Short line: 1280 B announced, only 100 beats
        do_reset();
        set_sp(8'h00, 16'd1);
        step("fs1", ex(1, 0, 0, 1, 4'b0000));
        for (int b = 0; b < 100; b++) begin
            set_beat(16'd1280);
            step($sformatf("short_beat%0d", b), ex(1, 1, 0, 1, 4'b0000));
        end
        set_quiet();
        step("short_end", ex(1, 0, 1, 1, 4'b1000));
        set_sp(8'h01, 16'h0000);
        step("short_fe", ex(0, 0, 1, 1, 4'b1000));

        // Line-count mismatch at FE (2 expected, 1 seen); data_valid drop ends the line
        do_reset();
        expected_lines = 16'd2;
        set_sp(8'h00, 16'd2);
        step("fs2", ex(1, 0, 0, 2, 4'b0000));
        set_beat(16'd9);
        step("l9_b0", ex(1, 1, 0, 2, 4'b0000));
        set_beat(16'd9);
        step("l9_b1", ex(1, 1, 0, 2, 4'b0000));
        data_valid = 1'b0;
        step("l9_dv_drop", ex(1, 0, 1, 2, 4'b0000));
        set_sp(8'h01, 16'h0000);
        step("count_mismatch_fe", ex(0, 0, 1, 2, 4'b1000));

        // FE arriving in LINE closes the line before the count check
        do_reset();
        expected_lines = 16'd1;
        set_sp(8'h00, 16'hABCD);
        step("fs_abcd", ex(1, 0, 0, 16'hABCD, 4'b0000));
        set_beat(16'd8);
        step("l8_b0", ex(1, 1, 0, 16'hABCD, 4'b0000));
        set_sp(8'h01, 16'h0000);
        step("fe_in_line", ex(0, 0, 1, 16'hABCD, 4'b0000));

        // Reset mid-LINE, then a clean frame
        set_quiet();
        expected_lines = 16'd0;
        set_sp(8'h00, 16'd3);
        step("fs3", ex(1, 0, 0, 3, 4'b0000));
        set_beat(16'd1280);
        step("pre_reset_beat", ex(1, 1, 0, 3, 4'b0000));
        set_sp(8'h01, 16'h0000);
        step("fe_dirty", ex(0, 0, 1, 3, 4'b1000));
        set_sp(8'h00, 16'd3);
        step("fs3b", ex(1, 0, 0, 3, 4'b0000));
        set_beat(16'd1280);
        step("mid_line", ex(1, 1, 0, 3, 4'b0000));
        do_reset();
        set_sp(8'h00, 16'd4);
        step("clean_fs", ex(1, 0, 0, 4, 4'b0000));

        // Idle timeout with default TIMEOUT_CYCLES
        do_reset();
        set_sp(8'h00, 16'd6);
        step("fs6", ex(1, 0, 0, 6, 4'b0000));
        set_quiet();
        for (int i = 1; i < 65535; i++) begin
            if (i == 1 || i == 65534) step($sformatf("idle%0d", i), ex(1, 0, 0, 6, 4'b0000));
            else begin
                @(posedge clk);
                #1;
            end
        end
        step("timeout", ex(0, 0, 0, 6, 4'b0100));
        step("timeout_hold", ex(0, 0, 0, 6, 4'b0100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mipi_csi_rx_frame_controller.md
MIPI_CSI_RX_FRAME_CONTROLLER -- requirements
Module: mipi_csi_rx_frame_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd65535: maximum idle cycles inside a frame before abort.
REQ-002 Parameter LANES, default 4: lane count; payload bytes per beat = LANES*2 = 8.
REQ-003 clk_i  input  1  MIPI byte clock; the only clock.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 data_valid_i  input  1  lane-aligned data valid from lane aligner.
REQ-006 data_i  input  64  lane-aligned bytes; sync byte at [7:0], data ID at [15:8], short-packet field at {[47:40],[31:24]}.
REQ-007 decoder_valid_i  input  1  payload-valid strobe from packet decoder.
REQ-008 packet_length_i  input  16  payload byte count reported by packet decoder.
REQ-009 expected_lines_i  input  16  lines per frame; 0 disables the line-count check.
REQ-010 frame_valid_o  output  1  high between accepted Frame Start and Frame End.
REQ-011 line_valid_o  output  1  registered copy of decoder_valid_i, gated by frame_valid.
REQ-012 line_count_o  output  16  lines completed in the current frame.
REQ-013 frame_number_o  output  16  frame number field latched from the last Frame Start.
REQ-014 error_o  output  4  sticky error flags, cleared by the next accepted Frame Start.

Function
REQ-015 A short packet is data_valid_i=1, data_i[7:0]=8'hB8 and data_i[15:8]=8'h00 (FS) or 8'h01 (FE).
REQ-016 States: IDLE, FRAME, LINE; the reset state is IDLE.
REQ-017 IDLE + FS -> FRAME: frame_valid_o=1, line_count_o=0, error_o=0, frame_number_o latched, all on the next edge.
REQ-018 IDLE + FE -> stay IDLE and set error_o[0] (FE without FS).
REQ-019 FRAME + decoder_valid_i=1 -> LINE: line_valid_o=1 on the next edge; beat counter loaded with ceil(packet_length_i/8)-1.
REQ-020 LINE: each beat with decoder_valid_i=1 decrements the beat counter.
REQ-021 LINE + falling decoder_valid_i -> FRAME: line_count_o increments (saturating at 16'hFFFF); line_valid_o=0 on the same edge.
REQ-022 A beat counter not at zero when the line ends sets error_o[3] (short line).
REQ-023 FRAME + FE -> IDLE: frame_valid_o=0 next edge.
REQ-024 If expected_lines_i!=0 and line_count_o!=expected_lines_i at FE, set error_o[3].
REQ-025 FS while in FRAME or LINE sets error_o[1] and restarts the frame as in REQ-017, except error_o[1] remains set.
REQ-026 An idle counter counts cycles in FRAME with no decoder_valid_i and no short packet; it is cleared on any activity.
REQ-027 Idle counter reaching TIMEOUT_CYCLES sets error_o[2] and forces IDLE with frame_valid_o=0.
REQ-028 FE arriving while in LINE first closes the line (count increments), then the frame, on the same edge.
REQ-029 data_valid_i=0 for any cycle in LINE ends the line as in REQ-021.
REQ-030 All outputs are registered; latency from input to output is one cycle.

Reset
REQ-031 During reset_i all outputs are 0, the state is IDLE, and all counters are 0.
REQ-032 Reset mid-frame drops frame_valid_o and line_valid_o asynchronously; no error flag is set.

Structure
REQ-033 The shared package holds: SYNC_BYTE 8'hB8, data IDs FS 8'h00 / FE 8'h01 / RAW10 8'h2B / RAW12 8'h2C / RAW14 8'h2D, and the state encoding.
REQ-034 The design is a single module with no sub-module; the idle timer stays inline.

Verification
REQ-035 FS (frame 16'h0005), 3 lines of 1280 B, FE, expected_lines_i=3 -> frame_valid_o high FS+1 to FE+1, line_count_o=3, frame_number_o=5, error_o=0.
REQ-036 FE with no FS -> error_o=4'b0001, frame_valid_o stays 0.
REQ-037 FS, 1 line, FS again -> error_o[1]=1, line_count_o=0, frame_valid_o stays 1.
REQ-038 FS then 65535 idle cycles (TIMEOUT_CYCLES default) -> error_o[2]=1, frame_valid_o=0 on the next edge.
REQ-039 Line with packet_length_i=1280 but only 100 valid beats -> error_o[3]=1, line_count_o=1.
REQ-040 reset_i asserted mid-LINE -> all outputs 0 immediately; the next FS starts a clean frame with error_o=0.
